// File: rtl/hist_cdf_lut.sv
// -----------------------------------------------------------------------------
// hist_cdf_lut
//
// Turns a finished histogram into a 64-entry equalisation LUT. On start, each
// of the num_bins histogram counts is read in turn and added into a running
// cumulative count (cdf). The cdf is scaled to an 8-bit level with a restoring
// divider that yields one quotient bit per cycle. Each level is written to the
// LUT RAM at the bin's address.
//
// Every bin takes exactly 11 cycles: READ 1, ACCUM 1, DIV 8, WRITE 1. The
// clamp and zero cases still run the full 8 DIV cycles, so run length depends
// only on num_bins.
//
// Optional feature (macro HIST_CDF_MIN_EN):
//   When defined, the block does classic equalisation. The first nonzero cdf
//   is latched as cdf_min. Each level is then
//   (cdf - cdf_min) * 255 / (total - cdf_min).
//   When undefined, the level is cdf * 255 / total and no cdf_min register
//   is built.
//
// Ports:
//   clk              in   1  clock, rising edge
//   rst              in   1  synchronous active-high reset
//   start            in   1  run request pulse, sampled only while idle
//   dim              in   9  image side length, total = dim*dim
//   num_bins         in   7  bins to process, 0..64 (larger values act as 64)
//   addr_hist_rd     out  6  histogram RAM read address (held outside READ)
//   dataout_hist     in  32  histogram RAM read data, one cycle latency;
//                            only bits [17:0] are used
//   writeEnable_lut  out  1  LUT RAM write strobe
//   addr_lut         out  6  LUT RAM write address
//   datain_lut       out  8  LUT RAM write data
//   busy             out  1  high whenever not idle
//   done             out  1  one-cycle completion pulse
// -----------------------------------------------------------------------------
module hist_cdf_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  dim,
  input  logic [6:0]  num_bins,
  output logic [5:0]  addr_hist_rd,
  input  logic [31:0] dataout_hist,
  output logic        writeEnable_lut,
  output logic [5:0]  addr_lut,
  output logic [7:0]  datain_lut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StAccum,
    StDiv,
    StWrite,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [18:0] cdf_q, cdf_d;
  logic [6:0]  bin_q, bin_d;
  logic [7:0]  q_q, q_d;
  logic [18:0] rem_q, rem_d;       // partial remainder of the divider
  logic [7:0]  nlo_q, nlo_d;       // low dividend bits, shifted in MSB first
  logic [2:0]  cnt_q, cnt_d;       // DIV cycle counter

`ifdef HIST_CDF_MIN_EN
  logic [18:0] cdf_min_q, cdf_min_d;
  logic        min_set_q, min_set_d;
`endif

  // Registered outputs
  logic [5:0]  addr_hist_q, addr_hist_d;
  logic        we_q, we_d;
  logic [5:0]  addr_lut_q, addr_lut_d;
  logic [7:0]  datain_q, datain_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [17:0] total;
  logic [6:0]  n_eff;
  logic [17:0] hist_cnt;
  logic        unused_hist_bits;
  logic [18:0] cdf_acc;
  logic [18:0] num_src;
  logic [26:0] num_scaled;
  logic [18:0] divisor;
  logic [18:0] rem_shift;
  logic [18:0] rem_sub;
  logic        ge;
  logic [7:0]  q_raw;
  logic [7:0]  q_final;

  assign total            = 18'(dim) * 18'(dim);
  assign n_eff            = (num_bins > 7'd64) ? 7'd64 : num_bins;
  assign hist_cnt         = dataout_hist[17:0];
  assign unused_hist_bits = ^dataout_hist[31:18];
  assign cdf_acc          = cdf_q + {1'b0, hist_cnt};

`ifdef HIST_CDF_MIN_EN
  // The bin that first makes the cdf nonzero uses its own updated cdf as the
  // floor, so its level comes out as 0.
  logic [18:0] min_eff;
  assign min_eff = (!min_set_q && (cdf_acc != 19'd0)) ? cdf_acc : cdf_min_q;
  assign num_src = cdf_acc - min_eff;
  assign divisor = {1'b0, total} - cdf_min_q;
`else
  assign num_src = cdf_acc;
  assign divisor = {1'b0, total};
`endif

  // x*255 as (x<<8) - x, so no multiplier is needed.
  assign num_scaled = {num_src, 8'd0} - {8'd0, num_src};

  // One restoring-division step. The top remainder bit is folded into the
  // compare so that a shifted-out bit still counts as "remainder >= divisor".
  assign rem_shift = {rem_q[17:0], nlo_q[7]};
  assign ge        = rem_q[18] | (rem_shift >= divisor);
  assign rem_sub   = rem_shift - divisor;
  assign q_raw     = {q_q[6:0], ge};

  // Special cases override whatever the divider produced.
  always_comb begin
    q_final = q_raw;
    if (total == 18'd0) begin
      q_final = 8'd0;
    end else if (cdf_q >= {1'b0, total}) begin
      q_final = 8'd255;
    end
`ifdef HIST_CDF_MIN_EN
    else if (min_set_q && (cdf_q < cdf_min_q)) begin
      q_final = 8'd0;
    end else if (divisor == 19'd0) begin
      q_final = 8'd255;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cdf_d   = cdf_q;
    bin_d   = bin_q;
    q_d     = q_q;
    rem_d   = rem_q;
    nlo_d   = nlo_q;
    cnt_d   = cnt_q;
`ifdef HIST_CDF_MIN_EN
    cdf_min_d = cdf_min_q;
    min_set_d = min_set_q;
`endif

    unique case (state_q)
      StIdle: begin
        cdf_d = '0;
        bin_d = '0;
        cnt_d = '0;
`ifdef HIST_CDF_MIN_EN
        cdf_min_d = '0;
        min_set_d = 1'b0;
`endif
        if (start) begin
          state_d = (num_bins == 7'd0) ? StDone : StRead;
        end
      end

      StRead: begin
        state_d = StAccum;
      end

      StAccum: begin
        cdf_d   = cdf_acc;
        // Upper dividend bits seed the remainder. They are below the divisor
        // whenever the quotient fits in 8 bits, i.e. in every non-clamp case.
        rem_d   = num_scaled[26:8];
        nlo_d   = num_scaled[7:0];
        cnt_d   = '0;
        state_d = StDiv;
`ifdef HIST_CDF_MIN_EN
        if (!min_set_q && (cdf_acc != 19'd0)) begin
          cdf_min_d = cdf_acc;
          min_set_d = 1'b1;
        end
`endif
      end

      StDiv: begin
        rem_d = ge ? rem_sub : rem_shift;
        nlo_d = {nlo_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_d     = q_final;
          state_d = StWrite;
        end else begin
          q_d = q_raw;
        end
      end

      StWrite: begin
        bin_d   = bin_q + 7'd1;
        state_d = ((bin_q + 7'd1) == n_eff) ? StDone : StRead;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to.
  always_comb begin
    we_d        = (state_d == StWrite);
    addr_lut_d  = we_d ? bin_q[5:0] : addr_lut_q;
    datain_d    = we_d ? q_d : datain_q;
    addr_hist_d = (state_d == StRead) ? bin_d[5:0] : addr_hist_q;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cdf_q       <= '0;
      bin_q       <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      nlo_q       <= '0;
      cnt_q       <= '0;
`ifdef HIST_CDF_MIN_EN
      cdf_min_q   <= '0;
      min_set_q   <= 1'b0;
`endif
      addr_hist_q <= '0;
      we_q        <= 1'b0;
      addr_lut_q  <= '0;
      datain_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cdf_q       <= cdf_d;
      bin_q       <= bin_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      nlo_q       <= nlo_d;
      cnt_q       <= cnt_d;
`ifdef HIST_CDF_MIN_EN
      cdf_min_q   <= cdf_min_d;
      min_set_q   <= min_set_d;
`endif
      addr_hist_q <= addr_hist_d;
      we_q        <= we_d;
      addr_lut_q  <= addr_lut_d;
      datain_q    <= datain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign addr_hist_rd    = addr_hist_q;
  assign writeEnable_lut = we_q;
  assign addr_lut        = addr_lut_q;
  assign datain_lut      = datain_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_hist_cdf_lut.sv
// -----------------------------------------------------------------------------
// Bench for hist_cdf_lut. A synchronous histogram RAM model feeds the DUT.
// LUT writes are captured once per cycle on the falling edge. Expected LUT
// contents are computed from the equalisation formula with integer
// arithmetic. Honours HIST_CDF_MIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hist_cdf_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  dim;
  logic [6:0]  num_bins;
  logic [5:0]  addr_hist_rd;
  logic [31:0] dataout_hist;
  logic        writeEnable_lut;
  logic [5:0]  addr_lut;
  logic [7:0]  datain_lut;
  logic        busy;
  logic        done;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] hist_mem [64];
  int          exp_lut  [64];
  int          got_lut  [64];

  always #5 clk = ~clk;

  hist_cdf_lut dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dim             (dim),
    .num_bins        (num_bins),
    .addr_hist_rd    (addr_hist_rd),
    .dataout_hist    (dataout_hist),
    .writeEnable_lut (writeEnable_lut),
    .addr_lut        (addr_lut),
    .datain_lut      (datain_lut),
    .busy            (busy),
    .done            (done)
  );

  // Histogram RAM: data valid the cycle after the address.
  always @(posedge clk) dataout_hist <= hist_mem[addr_hist_rd];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: running sum of counts, scaled to 0..255.
  function automatic void ref_lut(input int d, input int n);
    longint tot, cdf, cmin;
    bit     mset;
    tot  = longint'(d) * longint'(d);
    cdf  = 0;
    cmin = 0;
    mset = 0;
    for (int b = 0; b < 64; b++) exp_lut[b] = -1;
    for (int b = 0; b < n; b++) begin
      cdf += longint'(hist_mem[b][17:0]);
`ifdef HIST_CDF_MIN_EN
      if (!mset && cdf != 0) begin
        cmin = cdf;
        mset = 1;
      end
      if (tot == 0)           exp_lut[b] = 0;
      else if (cdf >= tot)    exp_lut[b] = 255;
      else if (cdf < cmin)    exp_lut[b] = 0;
      else                    exp_lut[b] = int'(((cdf - cmin) * 255) / (tot - cmin));
`else
      if (tot == 0)           exp_lut[b] = 0;
      else if (cdf >= tot)    exp_lut[b] = 255;
      else                    exp_lut[b] = int'((cdf * 255) / tot);
`endif
    end
  endfunction

  task automatic fill_const(input int v);
    for (int b = 0; b < 64; b++) hist_mem[b] = 32'(v);
  endtask

  // Random counts averaging about total/64 per bin, so runs mix scaled and
  // clamped entries. Upper RAM bits carry junk that must be ignored.
  task automatic fill_random(input int d);
    int tot;
    int c;
    tot = d * d;
    for (int b = 0; b < 64; b++) begin
      c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, tot / 32 + 1));
      hist_mem[b] = {14'($urandom), 18'(c)};
    end
  endtask

  // Starts a run, collects LUT writes until done and checks timing and
  // contents. extra_start >= 0 pulses start again at that cycle index.
  task automatic run_case(input int d, input int nb, input int extra_start, input string tag);
    int neff, k, wcnt, limit;
    bit seen_done, busy_seen;
    neff  = (nb > 64) ? 64 : nb;
    limit = 11 * 64 + 20;
    ref_lut(d, neff);
    for (int i = 0; i < 64; i++) got_lut[i] = -1;
    dim      = 9'(d);
    num_bins = 7'(nb);
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    k         = 0;
    wcnt      = 0;
    seen_done = 0;
    chk($sformatf("%s busy_rise", tag), 64'(busy), 64'd1);
    while (!seen_done && k <= limit) begin
      if (writeEnable_lut === 1'b1) begin
        chk($sformatf("%s wr_order", tag), 64'(addr_lut), 64'(wcnt));
        got_lut[addr_lut] = int'(datain_lut);
        wcnt++;
      end
      if (done === 1'b1) begin
        seen_done = 1;
      end else begin
        @(negedge clk);
        k++;
        start = (k == extra_start);
      end
    end
    start = 1'b0;
    chk($sformatf("%s done_seen", tag), 64'(seen_done), 64'd1);
    chk($sformatf("%s done_cycle", tag), 64'(k), 64'(11 * neff));
    chk($sformatf("%s wr_count", tag), 64'(wcnt), 64'(neff));
    for (int i = 0; i < neff; i++)
      chk($sformatf("%s lut[%0d]", tag, i), 64'(got_lut[i]), 64'(exp_lut[i]));
    @(negedge clk);
    chk($sformatf("%s done_pulse", tag), 64'(done), 64'd0);
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0) busy_seen = 1;
      @(negedge clk);
    end
    chk($sformatf("%s idle_after", tag), 64'(busy_seen), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dim      = '0;
    num_bins = '0;
    fill_const(0);
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst we", 64'(writeEnable_lut), 64'd0);
    chk("rst addr_lut", 64'(addr_lut), 64'd0);
    chk("rst datain", 64'(datain_lut), 64'd0);
    chk("rst addr_hist", 64'(addr_hist_rd), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Uniform histogram, one count per bin.
    fill_const(1);
    run_case(8, 64, -1, "uniform");
`ifdef HIST_CDF_MIN_EN
    chk("uniform lut0 const", 64'(got_lut[0]), 64'd0);
    chk("uniform lut1 const", 64'(got_lut[1]), 64'd4);
`else
    chk("uniform lut0 const", 64'(got_lut[0]), 64'd3);
    chk("uniform lut1 const", 64'(got_lut[1]), 64'd7);
    chk("uniform lut31 const", 64'(got_lut[31]), 64'd127);
`endif
    chk("uniform lut63 const", 64'(got_lut[63]), 64'd255);

    // All pixels in one bin.
    fill_const(0);
    hist_mem[10] = 32'd16;
    run_case(4, 64, -1, "single");
    chk("single lut9 const", 64'(got_lut[9]), 64'd0);
    chk("single lut10 const", 64'(got_lut[10]), 64'd255);

    // Degenerate: empty image, then zero bins.
    fill_random(8);
    run_case(0, 4, -1, "dim0");
    chk("dim0 lut3 const", 64'(got_lut[3]), 64'd0);
    run_case(8, 0, -1, "nbins0");

    // Counts exceeding the pixel total clamp to 255.
    fill_random(2);
    hist_mem[0] = 32'd9;
    run_case(2, 64, -1, "corrupt");
    chk("corrupt lut0 const", 64'(got_lut[0]), 64'd255);
    chk("corrupt lut63 const", 64'(got_lut[63]), 64'd255);

    // num_bins above 64 acts as 64.
    fill_random(50);
    run_case(50, 100, -1, "nbins100");

    // Random images.
    for (int it = 0; it < 6; it++) begin
      int d, nb;
      d  = int'($urandom_range(1, 511));
      nb = int'($urandom_range(1, 64));
      fill_random(d);
      run_case(d, nb, -1, $sformatf("rand%0d", it));
    end

    // Second start while busy must be ignored.
    fill_const(1);
    run_case(8, 64, 20, "busy_start");

    // Reset mid-run.
    fill_const(1);
    dim      = 9'd8;
    num_bins = 7'd64;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst we", 64'(writeEnable_lut), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    fill_random(13);
    run_case(13, 64, -1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_cdf_lut.md
# hist_cdf_lut

Downstream stage of the histogram controller. On `start` (the controller's completion pulse), reads the `num_bins` histogram counts from the histogram RAM, accumulates the cumulative distribution (CDF), and scales each CDF value to an 8-bit equalisation level with a bit-serial divider. Each level is written to a 64-entry LUT RAM, which is later read by the pixel-remap stage.

## Interface
- No parameters. Geometry is fixed: 64 bins maximum, 8-bit output levels.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse from the histogram controller. Sampled only in IDLE.
- `dim` in 9: image side length. `total = dim*dim`, 18 bits.
- `num_bins` in 7: number of bins to process, 0..64.
- `addr_hist_rd` out 6: histogram RAM read address.
- `dataout_hist` in 32: histogram RAM read data.
  - Valid the cycle after the address is presented.
  - Only bits [17:0] are used.
- `writeEnable_lut` out 1: LUT RAM write strobe.
- `addr_lut` out 6: LUT write address.
- `datain_lut` out 8: LUT write data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, READ, ACCUM, DIV, WRITE, DONE.
- **IDLE**
  - Clear `cdf` (19 bits) and `bin` (7 bits).
  - If `start`: go to DONE when `num_bins==0`, otherwise go to READ.
- **READ:** drive `addr_hist_rd = bin[5:0]`, then go to ACCUM.
- **ACCUM:** `cdf <= cdf + dataout_hist[17:0]`, then go to DIV.
- **DIV:** 8 cycles of restoring division producing `q = floor(cdf*255/total)`, MSB first.
  - Clamp rule: if `cdf >= total`, `q = 255`.
  - Zero rule: if `total == 0`, `q = 0`.
  - Clamp and zero cases still spend the full 8 DIV cycles, so cycle count is fixed.
  - After the 8th cycle, go to WRITE.
- **WRITE**
  - Drive `writeEnable_lut=1`, `addr_lut=bin[5:0]`, `datain_lut=q`.
  - `bin <= bin+1`.
  - If the new `bin == num_bins`, go to DONE; otherwise go to READ.
- **DONE:** `done=1` for one cycle, then go to IDLE.
- `num_bins > 64` is treated as 64.
- A `start` pulse while `busy` is ignored; it is neither queued nor restarts the run.
- `rst` at any time, including mid-run:
  - Next state is IDLE.
  - The in-progress LUT write is abandoned.
  - LUT entries already written are not cleared.
- Reset values: all outputs 0, `cdf=0`, `bin=0`, `q=0`.

## Timing
- Per bin: exactly 11 cycles (READ 1, ACCUM 1, DIV 8, WRITE 1).
- `done` is high during the cycle that begins 11·N edges after the edge that sampled `start`, where N is the effective `num_bins`.
  - With N=0, `done` is high the cycle after the sampling edge.
- `busy` goes high the cycle after `start` is sampled and is low again in the cycle after DONE.
- `writeEnable_lut` is high for exactly one cycle per bin. Bins are written in ascending address order.
- `addr_hist_rd` holds its last value outside READ. The histogram RAM is read-only from this block.
- `dim` and `num_bins` must be stable from `start` through `done`. They are sampled continuously, not latched.

## Configuration
- `HIST_CDF_MIN_EN` defined: classic equalisation.
  - In ACCUM, the first bin with a nonzero count latches `cdf_min = cdf` (the updated value).
  - Bins with `cdf < cdf_min` (still 0) output 0.
  - Other bins output `q = floor((cdf-cdf_min)*255/(total-cdf_min))`.
  - If `total == cdf_min`, bins with `cdf >= cdf_min` output 255.
  - The clamp rule applies to `cdf >= total`.
  - Cycle counts are unchanged.
- `HIST_CDF_MIN_EN` undefined: plain scaling as in Operation. No `cdf_min` register is built.

## Test plan
- **Uniform histogram:** `dim=8`, `num_bins=64`, every count 1.
  - LUT[0]=3, LUT[1]=7, LUT[31]=127, LUT[63]=255.
  - `done` exactly 704 cycles after the `start` edge.
- **Single-bin image:** `dim=4`, bin 10 count 16, all other bins 0.
  - LUT[0..9]=0, LUT[10..63]=255.
  - With `HIST_CDF_MIN_EN`: the same values.
- **Uniform histogram with `HIST_CDF_MIN_EN`:** same stimulus as the uniform case.
  - LUT[0]=0, LUT[1]=4, LUT[63]=255.
- **Degenerate inputs**
  - `dim=0`, `num_bins=4`: LUT[0..3]=0, `done` after 44 cycles.
  - `num_bins=0`: no LUT writes, `done` one cycle after `start`.
- **Corrupt counts:** `dim=2`, bin 0 count 9.
  - LUT[0]=255 (clamp), and all following bins are 255.
- **Busy and reset handling**
  - A second `start` pulse at cycle 20 is ignored: one `done` only, 64 writes.
  - `rst` at cycle 100: `busy`, `done` and `writeEnable_lut` are 0 the next cycle.
  - A subsequent `start` completes normally.
